mem_responder: RTL and testbench

Synchronous single-port memory that answers the `en`/`op`/`ready` request handshake driven by memory initiators (CPU load/store unit, test benches). It latches one request, completes it after a fixed programmable latency, and reports the result on `dataout`/`status`. It holds `ready` until the initiator releases the request. Storage survives reset, so a write followed by a reset and then a read returns the written data.

---
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one en/op request, completes it after
// LATENCY cycles and holds ready until the initiator releases en.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic [1:0]            status,
  output logic                  ready
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_OK    = 2'b01;
  localparam logic [1:0] ST_RANGE = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Storage is deliberately outside the reset domain so data survives reset.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  op_r, op_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] din_r, din_s;
  logic [DATA_WIDTH-1:0] dataout_r, dataout_s;
  logic [1:0]            status_r, status_s;
  logic                  ready_r, ready_s;
  logic                  mem_we_s;
  logic                  in_range_s;
  logic [IDX_W-1:0]      idx_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign in_range_s = ({1'b0, addr_r} < DEPTH_L);
  assign idx_s      = addr_r[IDX_W-1:0];
  assign rdata_s    = mem_r[idx_s];

  // Next-state, request latch and result computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    op_s      = op_r;
    addr_s    = addr_r;
    din_s     = din_r;
    dataout_s = dataout_r;
    status_s  = status_r;
    ready_s   = 1'b0;
    mem_we_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = BUSY;
          cnt_s   = CNT_LOAD;
          op_s    = op;
          addr_s  = addr;
          din_s   = datain;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!en) begin
          status_s = ST_ABORT;
          state_s  = IDLE;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s = DONE;
          ready_s = 1'b1;
          if (!in_range_s) begin
            status_s = ST_RANGE;
          end else begin
            status_s = ST_OK;
            if (op_r) begin
              mem_we_s = 1'b1;
            end else begin
              dataout_s = rdata_s;
            end
          end
        end
      end
      DONE: begin
        if (en) begin
          ready_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      din_r     <= {DATA_WIDTH{1'b0}};
      dataout_r <= {DATA_WIDTH{1'b0}};
      status_r  <= ST_NONE;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      addr_r    <= addr_s;
      din_r     <= din_s;
      dataout_r <= dataout_s;
      status_r  <= status_s;
      ready_r   <= ready_s;
    end
  end

  // Write port; a reset on the completion edge cancels the commit.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[idx_s] <= din_r;
    end
  end

  assign dataout = dataout_r;
  assign status  = status_r;
  assign ready   = ready_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: two responders (DEPTH=200/LAT=3 and
// DEPTH=256/LAT=1) checked against a transaction-level memory model.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic [1:0] reset;
  logic [1:0] en;
  logic [1:0] op;
  logic [1:0] ready;
  logic [7:0] addr    [2];
  logic [7:0] datain  [2];
  logic [7:0] dataout [2];
  logic [1:0] status  [2];

  logic [7:0] mmem  [2][256];
  logic [7:0] mdout [2];
  logic [1:0] mstat [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200), .LATENCY(3)) u0 (
    .clk(clk), .reset(reset[0]), .en(en[0]), .op(op[0]), .addr(addr[0]),
    .datain(datain[0]), .dataout(dataout[0]), .status(status[0]), .ready(ready[0])
  );

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset[1]), .en(en[1]), .op(op[1]), .addr(addr[1]),
    .datain(datain[1]), .dataout(dataout[1]), .status(status[1]), .ready(ready[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 3 : 1;
  endfunction

  function automatic int depth_of(input int u);
    return (u == 0) ? 200 : 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input int u, input string tag);
    check({tag, "_status"}, 32'(status[u]), 32'(mstat[u]));
    check({tag, "_dataout"}, 32'(dataout[u]), 32'(mdout[u]));
  endtask

  task automatic do_reset(input int u);
    @(negedge clk);
    reset[u] = 1'b1;
    en[u]    = 1'b0;
    @(negedge clk);
    mdout[u] = 8'h00;
    mstat[u] = 2'b00;
    check("rst_ready", 32'(ready[u]), 32'd0);
    check_outputs(u, "rst");
    reset[u] = 1'b0;
  endtask

  // One complete request: latency, result, optional hold, then release.
  task automatic do_req(input int u, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int hold);
    int  edges;
    bit  got;
    bit  hold_ok;
    @(negedge clk);
    en[u] = 1'b1; op[u] = wr; addr[u] = a; datain[u] = d;
    edges = 0;
    got   = 1'b0;
    while (edges < 20 && !got) begin
      @(negedge clk);
      edges++;
      if (ready[u]) begin
        got = 1'b1;
      end else begin
        op[u] = 1'($urandom); addr[u] = 8'($urandom); datain[u] = 8'($urandom);
      end
    end
    if (int'(a) < depth_of(u)) begin
      mstat[u] = 2'b01;
      if (wr) mmem[u][a] = d;
      else    mdout[u]   = mmem[u][a];
    end else begin
      mstat[u] = 2'b10;
    end
    check("latency", 32'(edges), 32'(lat_of(u) + 1));
    check_outputs(u, "done");
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!ready[u] || status[u] !== mstat[u] || dataout[u] !== mdout[u]) hold_ok = 1'b0;
      end
      check("hold_stable", 32'(hold_ok), 32'd1);
    end
    en[u] = 1'b0;
    @(negedge clk);
    check("release_ready", 32'(ready[u]), 32'd0);
    check_outputs(u, "release");
  endtask

  task automatic do_abort(input int u, input logic [7:0] a, input logic [7:0] d);
    bit quiet;
    @(negedge clk);
    en[u] = 1'b1; op[u] = 1'b1; addr[u] = a; datain[u] = d;
    @(negedge clk);
    quiet = !ready[u];
    @(negedge clk);
    quiet = quiet && !ready[u];
    en[u] = 1'b0;
    @(negedge clk);
    mstat[u] = 2'b11;
    quiet = quiet && !ready[u];
    check_outputs(u, "abort");
    @(negedge clk);
    quiet = quiet && !ready[u];
    check("abort_ready_low", 32'(quiet), 32'd1);
  endtask

  task automatic do_reset_mid(input int u, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    en[u] = 1'b1; op[u] = 1'b1; addr[u] = a; datain[u] = d;
    @(negedge clk);
    reset[u] = 1'b1;
    @(negedge clk);
    mdout[u] = 8'h00;
    mstat[u] = 2'b00;
    check("midrst_ready", 32'(ready[u]), 32'd0);
    check_outputs(u, "midrst");
    reset[u] = 1'b0;
    en[u]    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 256; i++) mmem[u][i] = 8'h00;
      mdout[u] = 8'h00; mstat[u] = 2'b00;
      addr[u] = 8'h00; datain[u] = 8'h00;
    end
    reset = 2'b11; en = 2'b00; op = 2'b00;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("init_ready", 32'(ready[u]), 32'd0);
      check_outputs(u, "init");
    end
    reset = 2'b00;

    for (int u = 0; u < 2; u++) begin
      do_req(u, 1'b1, 8'h08, 8'hF0, 0);
      do_reset(u);
      do_req(u, 1'b0, 8'h08, 8'h00, 0);
      do_req(u, 1'b1, 8'h09, 8'hF1, 0);
      do_reset(u);
      do_req(u, 1'b0, 8'h09, 8'h00, 0);
      if (u == 0) begin
        do_req(u, 1'b1, 8'hC8, 8'h12, 0);
        do_req(u, 1'b0, 8'hC8, 8'h00, 0);
        do_abort(u, 8'h0A, 8'h55);
        do_req(u, 1'b0, 8'h0A, 8'h00, 0);
      end
      do_reset_mid(u, 8'h0B, 8'hAA);
      do_req(u, 1'b0, 8'h0B, 8'h00, 0);
      do_req(u, 1'b1, 8'h20, 8'h77, 5);
      do_req(u, 1'b0, 8'h20, 8'h00, 5);
      do_req(u, 1'b1, 8'h21, 8'h3C, 0);
      do_req(u, 1'b0, 8'h21, 8'h00, 0);
      for (int k = 0; k < 40; k++) begin
        ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) do_reset(u);
        else do_req(u, 1'($urandom), ra, 8'($urandom), int'($urandom_range(0, 3)));
      end
      for (int a = 0; a < 16; a++) begin
        do_req(u, 1'b0, 8'(a), 8'h00, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
